// File: rtl/qc_fixed_pkg.sv
// Shared Q15.16 fixed-point constants and measurement-controller state encoding.
package qc_fixed_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;

    localparam logic [DATA_W-1:0] ONE  = 32'h0001_0000;
    localparam logic [DATA_W-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        NEXT_SHOT,
        DONE
    } meas_state_t;

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational priority encoder: index of the lowest set request bit plus an any-set flag.
module lsb_priority_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req[i] && !any_set) begin
                idx     = IDX_W'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_qubit_measure_unit.sv
// Multi-shot measurement of masked qubits: one random word per measurement,
// collapse write-back to state storage and per-qubit saturating '1' counts.
module multi_qubit_measure_unit #(
    parameter int NUM_QUBITS = 4,
    parameter int DATA_W     = 32,
    parameter int FRAC_W     = 16,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_QUBITS-1:0]        qubit_mask,
    input  logic [CNT_W-1:0]             shots,
    input  logic [NUM_QUBITS*DATA_W-1:0] prob_0_flat,
    input  logic [DATA_W-1:0]            rand_val,
    input  logic                         rand_valid,
    output logic                         rand_ready,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_QUBITS-1:0]        collapse_we,
    output logic [DATA_W-1:0]            new_alpha,
    output logic [DATA_W-1:0]            new_beta,
    output logic [NUM_QUBITS-1:0]        result_bits,
    output logic [NUM_QUBITS*CNT_W-1:0]  ones_count_flat
);

    import qc_fixed_pkg::*;

    localparam int IDX_W = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1;
    localparam logic [DATA_W-1:0] UNIT_ONE = DATA_W'(1) << FRAC_W;

    meas_state_t             state_q, state_d;
    logic [NUM_QUBITS-1:0]   mask_q, mask_d;
    logic [NUM_QUBITS-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]        shots_q, shots_d;
    logic [CNT_W-1:0]        shot_cnt_q, shot_cnt_d;
    logic [NUM_QUBITS-1:0]   collapse_we_q, collapse_we_d;
    logic [NUM_QUBITS-1:0]   result_bits_q, result_bits_d;
    logic [DATA_W-1:0]       new_alpha_q, new_alpha_d;
    logic [DATA_W-1:0]       new_beta_q, new_beta_d;
    logic [CNT_W-1:0]        ones_count_q [NUM_QUBITS];
    logic [CNT_W-1:0]        ones_count_d [NUM_QUBITS];

    logic [IDX_W-1:0]        tgt_idx;
    logic                    tgt_any;
    logic [NUM_QUBITS-1:0]   tgt_onehot;
    logic [DATA_W-1:0]       p0_sel;
    logic [DATA_W-1:0]       rand_frac;
    logic                    meas_bit;
    logic                    unused_rand_int;

    assign unused_rand_int = ^rand_val[DATA_W-1:FRAC_W];

    lsb_priority_enc #(
        .WIDTH (NUM_QUBITS),
        .IDX_W (IDX_W)
    ) u_enc (
        .req     (remaining_q),
        .idx     (tgt_idx),
        .any_set (tgt_any)
    );

    // Only the fraction of the random word is used; a negative p0 always yields '1'.
    always_comb begin
        tgt_onehot = '0;
        p0_sel     = '0;
        for (int unsigned i = 0; i < NUM_QUBITS; i++) begin
            if (IDX_W'(i) == tgt_idx) begin
                tgt_onehot[i] = 1'b1;
                p0_sel        = prob_0_flat[i*DATA_W +: DATA_W];
            end
        end
        rand_frac = {{(DATA_W-FRAC_W){1'b0}}, rand_val[FRAC_W-1:0]};
        meas_bit  = p0_sel[DATA_W-1] | ~(rand_frac < p0_sel);
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        remaining_d   = remaining_q;
        shots_d       = shots_q;
        shot_cnt_d    = shot_cnt_q;
        collapse_we_d = '0;
        result_bits_d = result_bits_q;
        new_alpha_d   = new_alpha_q;
        new_beta_d    = new_beta_q;
        ones_count_d  = ones_count_q;
        rand_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d      = qubit_mask;
                    shots_d     = shots;
                    remaining_d = qubit_mask;
                    shot_cnt_d  = '0;
                    for (int unsigned i = 0; i < NUM_QUBITS; i++) begin
                        ones_count_d[i] = '0;
                    end
                    state_d = (shots == '0 || qubit_mask == '0) ? DONE : MEASURE;
                end
            end
            MEASURE: begin
                rand_ready = 1'b1;
                if (rand_valid && tgt_any) begin
                    collapse_we_d = tgt_onehot;
                    new_alpha_d   = meas_bit ? '0 : UNIT_ONE;
                    new_beta_d    = meas_bit ? UNIT_ONE : '0;
                    for (int unsigned i = 0; i < NUM_QUBITS; i++) begin
                        if (tgt_onehot[i]) begin
                            result_bits_d[i] = meas_bit;
                            if (meas_bit && ones_count_q[i] != '1) begin
                                ones_count_d[i] = ones_count_q[i] + 1'b1;
                            end
                        end
                    end
                    remaining_d = remaining_q & ~tgt_onehot;
                    if (remaining_d == '0) begin
                        state_d = NEXT_SHOT;
                    end
                end
            end
            NEXT_SHOT: begin
                shot_cnt_d = shot_cnt_q + 1'b1;
                if (shot_cnt_d == shots_q) begin
                    state_d = DONE;
                end else begin
                    remaining_d = mask_q;
                    state_d     = MEASURE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            remaining_q   <= '0;
            shots_q       <= '0;
            shot_cnt_q    <= '0;
            collapse_we_q <= '0;
            result_bits_q <= '0;
            new_alpha_q   <= UNIT_ONE;
            new_beta_q    <= '0;
            for (int unsigned i = 0; i < NUM_QUBITS; i++) begin
                ones_count_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            remaining_q   <= remaining_d;
            shots_q       <= shots_d;
            shot_cnt_q    <= shot_cnt_d;
            collapse_we_q <= collapse_we_d;
            result_bits_q <= result_bits_d;
            new_alpha_q   <= new_alpha_d;
            new_beta_q    <= new_beta_d;
            ones_count_q  <= ones_count_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign collapse_we = collapse_we_q;
    assign new_alpha   = new_alpha_q;
    assign new_beta    = new_beta_q;
    assign result_bits = result_bits_q;

    always_comb begin
        ones_count_flat = '0;
        for (int unsigned i = 0; i < NUM_QUBITS; i++) begin
            ones_count_flat[i*CNT_W +: CNT_W] = ones_count_q[i];
        end
    end

endmodule

// File: tb/tb_multi_qubit_measure_unit.sv
// Directed self-checking bench for multi_qubit_measure_unit (4 qubits, Q15.16, 16-bit counts).
module tb_multi_qubit_measure_unit;

    localparam logic [31:0] ONE = 32'h0001_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   qubit_mask;
    logic [15:0]  shots;
    logic [127:0] prob_0_flat;
    logic [31:0]  rand_val;
    logic         rand_valid;
    logic         rand_ready;
    logic         busy;
    logic         done;
    logic [3:0]   collapse_we;
    logic [31:0]  new_alpha;
    logic [31:0]  new_beta;
    logic [3:0]   result_bits;
    logic [63:0]  ones_count_flat;

    multi_qubit_measure_unit #(
        .NUM_QUBITS (4),
        .DATA_W     (32),
        .FRAC_W     (16),
        .CNT_W      (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .qubit_mask      (qubit_mask),
        .shots           (shots),
        .prob_0_flat     (prob_0_flat),
        .rand_val        (rand_val),
        .rand_valid      (rand_valid),
        .rand_ready      (rand_ready),
        .busy            (busy),
        .done            (done),
        .collapse_we     (collapse_we),
        .new_alpha       (new_alpha),
        .new_beta        (new_beta),
        .result_bits     (result_bits),
        .ones_count_flat (ones_count_flat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] b;
    } strobe_t;

    strobe_t log_q[$];
    int done_cnt = 0;
    int busy_cyc = 0;
    int log_base, done_base, busy_base;
    int errors = 0;
    int checks = 0;

    // Observer: mid-cycle sampling of strobes, done pulses and busy cycles.
    always @(negedge clk) begin
        if (collapse_we != 4'b0000) log_q.push_back('{we: collapse_we, a: new_alpha, b: new_beta});
        if (done) done_cnt++;
        if (busy) busy_cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_strobe(input string tag, input int k, input logic [3:0] we, input logic bit_v);
        strobe_t e;
        e = log_q[log_base + k];
        check({tag, "_we"},    64'(e.we), 64'(we));
        check({tag, "_alpha"}, 64'(e.a),  bit_v ? 64'h0 : 64'(ONE));
        check({tag, "_beta"},  64'(e.b),  bit_v ? 64'(ONE) : 64'h0);
    endtask

    task automatic start_run(input logic [3:0] m, input logic [15:0] n);
        @(posedge clk); #1;
        log_base  = log_q.size();
        done_base = done_cnt;
        busy_base = busy_cyc;
        @(negedge clk);
        qubit_mask = m;
        shots      = n;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done_cnt == done_base && n < max_cyc);
        check({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; qubit_mask = '0; shots = '0;
        prob_0_flat = '0; rand_val = '0; rand_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rand_ready", 64'(rand_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we", 64'(collapse_we), 64'd0);
        check("rst_alpha", 64'(new_alpha), 64'(ONE));
        check("rst_beta", 64'(new_beta), 64'd0);
        check("rst_result", 64'(result_bits), 64'd0);
        check("rst_counts", ones_count_flat, 64'd0);
        @(negedge clk) reset = 1'b0;

        // single qubit, r=0.25 < p0=0.5 -> |0>
        prob_0_flat = {32'h0, 32'h0, 32'h0, 32'h0000_8000};
        rand_val = 32'h0000_4000; rand_valid = 1'b1;
        start_run(4'b0001, 16'd1);
        wait_done("t1", 20);
        check("t1_nstrobe", 64'(log_q.size() - log_base), 64'd1);
        chk_strobe("t1_s0", 0, 4'b0001, 1'b0);
        check("t1_counts", ones_count_flat, 64'd0);
        check("t1_result", 64'(result_bits), 64'b0000);
        check("t1_busy_cycles", 64'(busy_cyc - busy_base), 64'd3);

        // p0=0 -> always |1>; order q1,q3 per shot
        prob_0_flat = '0; rand_val = 32'h0000_1234;
        start_run(4'b1010, 16'd3);
        wait_done("t2", 60);
        check("t2_nstrobe", 64'(log_q.size() - log_base), 64'd6);
        for (int k = 0; k < 6; k++) chk_strobe($sformatf("t2_s%0d", k), k, (k % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1);
        check("t2_counts", ones_count_flat, {16'd3, 16'd0, 16'd3, 16'd0});
        check("t2_result", 64'(result_bits), 64'b1010);
        check("t2_busy_cycles", 64'(busy_cyc - busy_base), 64'd10);

        // p0 >= ONE with frac 0xFFFF -> 0; integer bits of rand ignored
        prob_0_flat = {32'h0001_0001, 32'h0, 32'h0, ONE};
        rand_val = 32'h7FFF_FFFF;
        start_run(4'b1001, 16'd1);
        wait_done("t3a", 20);
        check("t3a_nstrobe", 64'(log_q.size() - log_base), 64'd2);
        chk_strobe("t3a_s0", 0, 4'b0001, 1'b0);
        chk_strobe("t3a_s1", 1, 4'b1000, 1'b0);
        check("t3a_result", 64'(result_bits), 64'b0010);
        check("t3a_counts", ones_count_flat, 64'd0);

        // negative p0 with frac 0 -> 1; p0=0xFFFF with frac 0 -> 0
        prob_0_flat = {32'h0, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0};
        rand_val = 32'hABCD_0000;
        start_run(4'b0110, 16'd1);
        wait_done("t3b", 20);
        check("t3b_nstrobe", 64'(log_q.size() - log_base), 64'd2);
        chk_strobe("t3b_s0", 0, 4'b0010, 1'b1);
        chk_strobe("t3b_s1", 1, 4'b0100, 1'b0);
        check("t3b_result", 64'(result_bits), 64'b0010);
        check("t3b_counts", ones_count_flat, 64'h0000_0000_0001_0000);

        // 5-cycle stall after the first handshake
        prob_0_flat = {32'h0, 32'h0, 32'h0000_D000, 32'h0000_8000};
        rand_val = 32'h0000_C000; rand_valid = 1'b1;
        start_run(4'b0011, 16'd2);
        @(negedge clk) rand_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("t4_stall_we%0d", k), 64'(collapse_we), 64'd0);
            check($sformatf("t4_stall_ready%0d", k), 64'(rand_ready), 64'd1);
        end
        check("t4_stall_nstrobe", 64'(log_q.size() - log_base), 64'd1);
        @(negedge clk) rand_valid = 1'b1;
        wait_done("t4", 40);
        check("t4_nstrobe", 64'(log_q.size() - log_base), 64'd4);
        for (int k = 0; k < 4; k++) chk_strobe($sformatf("t4_s%0d", k), k, (k % 2 == 0) ? 4'b0001 : 4'b0010, (k % 2 == 0));
        check("t4_counts", ones_count_flat, 64'h2);
        check("t4_result", 64'(result_bits), 64'b0001);
        check("t4_busy_cycles", 64'(busy_cyc - busy_base), 64'd12);

        // shots=0 and mask=0 go straight to DONE and clear counts
        start_run(4'b1111, 16'd0);
        wait_done("t5a", 10);
        check("t5a_nstrobe", 64'(log_q.size() - log_base), 64'd0);
        check("t5a_busy_cycles", 64'(busy_cyc - busy_base), 64'd1);
        check("t5a_counts", ones_count_flat, 64'd0);
        check("t5a_result", 64'(result_bits), 64'b0001);
        start_run(4'b0000, 16'd5);
        wait_done("t5b", 10);
        check("t5b_nstrobe", 64'(log_q.size() - log_base), 64'd0);
        check("t5b_busy_cycles", 64'(busy_cyc - busy_base), 64'd1);

        // start, mask and shots changed while busy are ignored
        prob_0_flat = {32'h0, 32'h0, 32'h0, 32'h0000_8000};
        rand_val = 32'h0000_C000; rand_valid = 1'b0;
        start_run(4'b0001, 16'd2);
        @(negedge clk);
        qubit_mask = 4'b1111; shots = 16'd1; start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) rand_valid = 1'b1;
        wait_done("t5c", 30);
        check("t5c_nstrobe", 64'(log_q.size() - log_base), 64'd2);
        chk_strobe("t5c_s0", 0, 4'b0001, 1'b1);
        chk_strobe("t5c_s1", 1, 4'b0001, 1'b1);
        check("t5c_counts", ones_count_flat, 64'h2);
        repeat (3) @(posedge clk);
        #1 check("t5c_no_rerun", 64'(done_cnt - done_base), 64'd1);

        // reset during MEASURE of shot 2
        prob_0_flat = '0; rand_val = 32'h0;
        start_run(4'b0011, 16'd3);
        n = 0;
        while (log_q.size() - log_base < 3 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("t6_reach_shot2", 64'(log_q.size() - log_base), 64'd3);
        reset = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_ready", 64'(rand_ready), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_we", 64'(collapse_we), 64'd0);
        check("t6_rst_alpha", 64'(new_alpha), 64'(ONE));
        check("t6_rst_beta", 64'(new_beta), 64'd0);
        check("t6_rst_result", 64'(result_bits), 64'd0);
        check("t6_rst_counts", ones_count_flat, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", 64'(done_cnt - done_base), 64'd0);
        check("t6_no_strobe", 64'(log_q.size() - log_base), 64'd3);
        check("t6_idle_ready", 64'(rand_ready), 64'd0);
        start_run(4'b0100, 16'd2);
        wait_done("t6n", 30);
        check("t6n_nstrobe", 64'(log_q.size() - log_base), 64'd2);
        chk_strobe("t6n_s0", 0, 4'b0100, 1'b1);
        chk_strobe("t6n_s1", 1, 4'b0100, 1'b1);
        check("t6n_counts", ones_count_flat, 64'h0000_0002_0000_0000);
        check("t6n_result", 64'(result_bits), 64'b0100);
        check("t6n_busy_cycles", 64'(busy_cyc - busy_base), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
